// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the two-slot VLIW core with load-use hazard
// detection. A load in EX whose Sd feeds a source read in ID stalls ID for
// one cycle and a bubble enters EX instead. Branch flush and downstream hold
// are honoured, with flush taking precedence over hold.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [6*RA_W-1:0]   id_regs,
  input  logic [3:0]          id_src_used,
  input  logic [3:0]          id_ctrl,
  input  logic [5*DATA_W-1:0] id_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                flush,
  input  logic                hold,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [RA_W-1:0]     ex_rm,
  output logic [RA_W-1:0]     ex_rn,
  output logic [RA_W-1:0]     ex_rd,
  output logic [RA_W-1:0]     ex_sm,
  output logic [RA_W-1:0]     ex_sn,
  output logic [RA_W-1:0]     ex_sd,
  output logic                ex_rregwrite,
  output logic                ex_sregwrite,
  output logic                ex_mr,
  output logic                ex_mw,
  output logic [5*DATA_W-1:0] ex_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [CNT_W-1:0]    bubble_count
);

  logic [RA_W-1:0] id_rm, id_rn, id_rd, id_sm, id_sn, id_sd;
  logic [3:0]      src_match;
  logic            lu;

  assign id_rm = id_regs[6*RA_W-1 -: RA_W];
  assign id_rn = id_regs[5*RA_W-1 -: RA_W];
  assign id_rd = id_regs[4*RA_W-1 -: RA_W];
  assign id_sm = id_regs[3*RA_W-1 -: RA_W];
  assign id_sn = id_regs[2*RA_W-1 -: RA_W];
  assign id_sd = id_regs[RA_W-1:0];

  // A source matches the load destination only if that operand is really read;
  // both R and S slot sources are compared against the S slot load.
  assign src_match[3] = id_src_used[3] & (id_rm == ex_sd);
  assign src_match[2] = id_src_used[2] & (id_rn == ex_sd);
  assign src_match[1] = id_src_used[1] & (id_sm == ex_sd);
  assign src_match[0] = id_src_used[0] & (id_sn == ex_sd);

  // Loads to register 0 never produce a value worth waiting for.
  assign lu = ex_valid & ex_mr & (ex_sd != '0) & id_valid & (|src_match);

  // Hold also freezes ID so that it stays aligned with the frozen EX stage.
  assign id_stall = ~rst & (lu | hold);

  // Operand data and immediate: loaded whenever EX is not frozen; their value
  // is irrelevant when the control bits mark the slot as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_data <= '0;
      ex_imm  <= '0;
    end else if (flush || !hold) begin
      ex_data <= id_data;
      ex_imm  <= id_imm;
    end
  end

  // Control, specifiers and bubble counter: reset, flush, hold, bubble, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rm        <= '0;
      ex_rn        <= '0;
      ex_rd        <= '0;
      ex_sm        <= '0;
      ex_sn        <= '0;
      ex_sd        <= '0;
      ex_rregwrite <= 1'b0;
      ex_sregwrite <= 1'b0;
      ex_mr        <= 1'b0;
      ex_mw        <= 1'b0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_rregwrite <= 1'b0;
      ex_sregwrite <= 1'b0;
      ex_mr        <= 1'b0;
      ex_mw        <= 1'b0;
      ex_rm        <= id_rm;
      ex_rn        <= id_rn;
      ex_rd        <= id_rd;
      ex_sm        <= id_sm;
      ex_sn        <= id_sn;
      ex_sd        <= id_sd;
    end else if (!hold) begin
      if (lu) begin
        ex_valid     <= 1'b0;
        ex_rregwrite <= 1'b0;
        ex_sregwrite <= 1'b0;
        ex_mr        <= 1'b0;
        ex_mw        <= 1'b0;
        ex_rm        <= '0;
        ex_rn        <= '0;
        ex_rd        <= '0;
        ex_sm        <= '0;
        ex_sn        <= '0;
        ex_sd        <= '0;
        if (bubble_count != '1) begin
          bubble_count <= bubble_count + CNT_W'(1);
        end
      end else begin
        ex_valid     <= id_valid;
        ex_rregwrite <= id_ctrl[3] & id_valid;
        ex_sregwrite <= id_ctrl[2] & id_valid;
        ex_mr        <= id_ctrl[1] & id_valid;
        ex_mw        <= id_ctrl[0] & id_valid;
        ex_rm        <= id_rm;
        ex_rn        <= id_rn;
        ex_rd        <= id_rd;
        ex_sm        <= id_sm;
        ex_sn        <= id_sn;
        ex_sd        <= id_sd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: a driver applies directed and random
// instructions and pushes expectations from a field-level model; a monitor
// pops them on the falling edge and compares against two instances (default
// counter width and a 2-bit saturating counter).
module tb_id_ex_hazard_reg;

  localparam int DW = 32;
  localparam int RW = 3;

  typedef struct {
    bit         valid;
    bit [17:0]  regs;
    bit         regs_known;
    bit [3:0]   ctrl;
    bit [159:0] data;
    bit [31:0]  imm;
    bit         data_known;
    int         cnt;
    bit         stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, id_valid = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [6*RW-1:0]   id_regs = '0;
  logic [3:0]        id_src_used = '0, id_ctrl = '0;
  logic [5*DW-1:0]   id_data = '0;
  logic [DW-1:0]     id_imm = '0;

  logic a_stall, a_valid, a_rr, a_sr, a_mr, a_mw;
  logic [RW-1:0] a_rm, a_rn, a_rd, a_sm, a_sn, a_sd;
  logic [5*DW-1:0] a_data;
  logic [DW-1:0] a_imm;
  logic [15:0] a_cnt;

  logic b_stall, b_valid, b_rr, b_sr, b_mr, b_mw;
  logic [RW-1:0] b_rm, b_rn, b_rd, b_sm, b_sn, b_sd;
  logic [5*DW-1:0] b_data;
  logic [DW-1:0] b_imm;
  logic [1:0] b_cnt;

  id_ex_hazard_reg #(.DATA_W(DW), .RA_W(RW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regs(id_regs),
    .id_src_used(id_src_used), .id_ctrl(id_ctrl), .id_data(id_data),
    .id_imm(id_imm), .flush(flush), .hold(hold), .id_stall(a_stall),
    .ex_valid(a_valid), .ex_rm(a_rm), .ex_rn(a_rn), .ex_rd(a_rd),
    .ex_sm(a_sm), .ex_sn(a_sn), .ex_sd(a_sd), .ex_rregwrite(a_rr),
    .ex_sregwrite(a_sr), .ex_mr(a_mr), .ex_mw(a_mw), .ex_data(a_data),
    .ex_imm(a_imm), .bubble_count(a_cnt)
  );

  id_ex_hazard_reg #(.DATA_W(DW), .RA_W(RW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regs(id_regs),
    .id_src_used(id_src_used), .id_ctrl(id_ctrl), .id_data(id_data),
    .id_imm(id_imm), .flush(flush), .hold(hold), .id_stall(b_stall),
    .ex_valid(b_valid), .ex_rm(b_rm), .ex_rn(b_rn), .ex_rd(b_rd),
    .ex_sm(b_sm), .ex_sn(b_sn), .ex_sd(b_sd), .ex_rregwrite(b_rr),
    .ex_sregwrite(b_sr), .ex_mr(b_mr), .ex_mw(b_mw), .ex_data(b_data),
    .ex_imm(b_imm), .bubble_count(b_cnt)
  );

  // Reference model of the EX stage: specifier array index 0..5 is rm,rn,rd,sm,sn,sd;
  // control array index 0..3 is rregwrite,sregwrite,mr,mw.
  int         m_valid;
  int         m_reg[6];
  int         m_ctrl[4];
  logic [159:0] m_data;
  logic [31:0]  m_imm;
  bit         m_regs_known, m_data_known;
  int         m_cnt;
  bit         last_stall = 1'b0;

  exp_t sb[$];
  int   num_checks = 0;
  int   num_errors = 0;

  function automatic int get_reg(int k);
    return int'((id_regs >> (3 * (5 - k))) & 18'h7);
  endfunction

  function automatic logic [17:0] regs6(int a, int b, int c, int d, int e, int f);
    return {3'(a), 3'(b), 3'(c), 3'(d), 3'(e), 3'(f)};
  endfunction

  // Load-use rule: EX holds a valid load to a nonzero register read by ID.
  function automatic bit model_lu();
    int pos[4] = '{0, 1, 3, 4};
    if (m_valid == 0 || m_ctrl[2] == 0 || m_reg[5] == 0 || !id_valid) return 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (id_src_used[3-j] && get_reg(pos[j]) == m_reg[5]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic updateModel();
    bit hit;
    hit = model_lu();
    if (rst) begin
      m_valid = 0;
      for (int k = 0; k < 6; k++) m_reg[k] = 0;
      for (int c = 0; c < 4; c++) m_ctrl[c] = 0;
      m_data = '0;
      m_imm = '0;
      m_regs_known = 1'b1;
      m_data_known = 1'b1;
      m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
      for (int c = 0; c < 4; c++) m_ctrl[c] = 0;
      m_regs_known = 1'b0;
      m_data_known = 1'b0;
    end else if (hold) begin
      m_valid = m_valid;
    end else if (hit) begin
      m_valid = 0;
      for (int k = 0; k < 6; k++) m_reg[k] = 0;
      for (int c = 0; c < 4; c++) m_ctrl[c] = 0;
      m_regs_known = 1'b1;
      m_data_known = 1'b0;
      m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid ? 1 : 0;
      for (int k = 0; k < 6; k++) m_reg[k] = get_reg(k);
      for (int c = 0; c < 4; c++) m_ctrl[c] = (id_valid && id_ctrl[3-c]) ? 1 : 0;
      m_data = id_data;
      m_imm = id_imm;
      m_regs_known = 1'b1;
      m_data_known = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit h, input bit v,
                               input logic [17:0] regs, input logic [3:0] used,
                               input logic [3:0] ctrl);
    exp_t e;
    @(posedge clk);
    updateModel();
    #1;
    rst = r; flush = f; hold = h; id_valid = v;
    id_regs = regs; id_src_used = used; id_ctrl = ctrl;
    id_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    id_imm = $urandom();
    e.valid = (m_valid != 0);
    e.regs = regs6(m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_reg[5]);
    e.regs_known = m_regs_known;
    e.ctrl = {m_ctrl[0] != 0, m_ctrl[1] != 0, m_ctrl[2] != 0, m_ctrl[3] != 0};
    e.data = m_data;
    e.imm = m_imm;
    e.data_known = m_data_known;
    e.cnt = m_cnt;
    e.stall = !rst && (hold || model_lu());
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("id_stall", 160'(a_stall), 160'(e.stall));
        checkOutput("id_stall_b", 160'(b_stall), 160'(e.stall));
        checkOutput("ex_valid", 160'(a_valid), 160'(e.valid));
        checkOutput("ex_ctrl", 160'({a_rr, a_sr, a_mr, a_mw}), 160'(e.ctrl));
        checkOutput("bubble_count", 160'(a_cnt), 160'(e.cnt));
        checkOutput("bubble_count_sat2", 160'(b_cnt), 160'((e.cnt > 3) ? 3 : e.cnt));
        if (e.regs_known)
          checkOutput("ex_regs", 160'({a_rm, a_rn, a_rd, a_sm, a_sn, a_sd}), 160'(e.regs));
        if (e.data_known) begin
          checkOutput("ex_data", a_data, e.data);
          checkOutput("ex_imm", 160'(a_imm), 160'(e.imm));
        end
      end
    end
  end

  initial begin
    logic [17:0] r_regs;
    logic [3:0]  r_used, r_ctrl;
    bit          r_valid;
    r_regs = '0; r_used = '0; r_ctrl = '0; r_valid = 1'b0;

    // Reset, then a plain R-slot instruction
    applyStimulus(1, 0, 0, 0, '0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 0, 0, '0, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 0, 1, regs6(1, 2, 3, 4, 5, 6), 4'b0000, 4'b1000);

    // Load-use on rm: stall, bubble, then capture of the stalled instruction
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 3), 4'b0000, 4'b0110);
    applyStimulus(0, 0, 0, 1, regs6(3, 0, 1, 0, 0, 0), 4'b1000, 4'b1000);
    applyStimulus(0, 0, 0, 1, regs6(3, 0, 1, 0, 0, 0), 4'b1000, 4'b1000);
    applyStimulus(0, 0, 0, 1, regs6(3, 0, 1, 0, 0, 0), 4'b1000, 4'b1000);

    // No stall: operand not read, then load to register 0
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 3), 4'b0000, 4'b0110);
    applyStimulus(0, 0, 0, 1, regs6(3, 3, 0, 3, 3, 0), 4'b0000, 4'b1000);
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 0), 4'b0000, 4'b0010);
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 0), 4'b1111, 4'b1000);
    // S-slot source hazard
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 5), 4'b0000, 4'b0010);
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 5, 0), 4'b0001, 4'b0100);
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 5, 0), 4'b0001, 4'b0100);

    // Flush together with hazard and hold
    applyStimulus(0, 0, 0, 1, regs6(0, 0, 0, 0, 0, 3), 4'b0000, 4'b0110);
    applyStimulus(0, 1, 1, 1, regs6(3, 0, 0, 0, 0, 0), 4'b1000, 4'b1100);
    applyStimulus(0, 0, 0, 1, regs6(2, 2, 2, 2, 2, 2), 4'b0000, 4'b1111);

    // Hold for three cycles mid-stream
    applyStimulus(0, 1, 0, 0, '0, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 0, 1, regs6(7, 6, 5, 4, 3, 2), 4'b0000, 4'b1101);
    applyStimulus(0, 0, 1, 1, regs6(1, 1, 1, 1, 1, 1), 4'b0000, 4'b0000);
    applyStimulus(0, 0, 1, 0, regs6(2, 3, 4, 5, 6, 7), 4'b1111, 4'b1111);
    applyStimulus(0, 0, 1, 1, regs6(4, 4, 4, 4, 4, 4), 4'b0101, 4'b0011);
    applyStimulus(0, 0, 0, 1, regs6(4, 4, 4, 4, 4, 4), 4'b0101, 4'b0011);

    // Back-to-back dependent loads: five bubbles, saturating the 2-bit counter
    applyStimulus(1, 0, 0, 0, '0, 4'b0000, 4'b0000);
    for (int n = 0; n < 11; n++)
      applyStimulus(0, 0, 0, 1, regs6(3, 0, 0, 0, 0, 3), 4'b1000, 4'b0110);

    // Randomized traffic; a stalled ID keeps presenting its instruction
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        r_valid = ($urandom_range(0, 9) != 0);
        r_regs = 18'($urandom());
        r_used = 4'($urandom());
        r_ctrl = 4'($urandom());
        if ($urandom_range(0, 1) == 1) r_ctrl[1] = 1'b1;
      end
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 7) == 0, r_valid, r_regs, r_used, r_ctrl);
    end
    applyStimulus(0, 0, 0, 0, '0, 4'b0000, 4'b0000);

    for (int t = 0; t < 5 && sb.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      num_errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
